// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word request at a time and
// hands the fetched word to the decoder. Optional macro: FETCH_DELAY_SLOT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             dobranch,
  input  logic             dojump,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [CNT_W-1:0] instret_q;

  logic             accept;
  logic             retire;
  logic             taken;
  logic [31:0]      pc4;
  logic [31:0]      br_target;
  logic [31:0]      jmp_target;
  logic [31:0]      redirect_target;
  logic [31:0]      next_pc;

  // NOTE: every signal gets a default at the top of the block so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      FETCH: begin
        // run_q keeps the request low until the first edge after reset release.
        imem_req = run_q;
        accept   = run_q & imem_ready;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        retire      = ~stall;
        if (retire) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc4             = pc_q + 32'd4;
    br_target       = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    jmp_target      = {pc4[31:28], instr_q[25:0], 2'b00};
    taken           = dojump | dobranch;
    redirect_target = dojump ? jmp_target : br_target;
  end

`ifdef FETCH_DELAY_SLOT_EN
  logic        pend_valid_q;
  logic [31:0] pend_target_q;

  // The slot instruction falls through to pc4; the recorded redirect lands
  // after it, and decoder outputs on the slot itself are not acted on.
  always_comb begin
    next_pc = pend_valid_q ? pend_target_q : pc4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else if (retire) begin
      if (pend_valid_q) begin
        pend_valid_q <= 1'b0;
      end else if (taken) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= redirect_target;
      end
    end
  end
`else
  always_comb begin
    next_pc = taken ? redirect_target : pc4;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (accept) instr_q <= imem_rdata;
      if (retire) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// handshakes against a transaction-level model of the fetch/retire rules.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HI_PC    = 32'h3000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_ready, instr_valid, stall, dobranch, dojump;
  logic [31:0] imem_addr, imem_rdata, instr, pc, instret;

  logic        imem_req_hi, instr_valid_hi;
  logic [31:0] imem_addr_hi, instr_hi, pc_hi;
  logic [3:0]  instret_hi;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  bit          exp_have;
  bit          pend;
  logic [31:0] pend_tgt;
  logic [31:0] fetch_log[$];
  logic [31:0] ov[logic [31:0]];
  int          hi_idx;
  bit          hi_have;
  logic [3:0]  hi_retired;

  fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .dobranch(dobranch), .dojump(dojump), .pc(pc), .instret(instret)
  );

  // Second instance: high reset PC, always jumping, 4-bit retire counter.
  fetch_unit #(.RESET_PC(HI_PC), .CNT_W(4)) dut_hi (
    .clk(clk), .reset(reset),
    .imem_req(imem_req_hi), .imem_addr(imem_addr_hi), .imem_ready(1'b1), .imem_rdata(32'h0000_0040),
    .instr(instr_hi), .instr_valid(instr_valid_hi), .stall(1'b0),
    .dobranch(1'b0), .dojump(1'b1), .pc(pc_hi), .instret(instret_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ov.exists(a)) return ov[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic [31:0] hi_addr(input int idx);
    if (idx == 0) return HI_PC;
`ifdef FETCH_DELAY_SLOT_EN
    if (idx == 1) return HI_PC + 32'h4;
    return (idx % 2 == 0) ? 32'h3000_0100 : 32'h3000_0104;
`else
    return 32'h3000_0100;
`endif
  endfunction

  // Called at a falling edge: check outputs, then drive inputs for the next
  // rising edge and advance the model by that edge.
  task automatic step(input bit rdy, input bit stl, input bit br, input bit jp);
    logic [31:0] ins, pc4, tgt;
    check("valid", instr_valid, exp_have);
    check("req", imem_req, !exp_have);
    check("pc", pc, exp_pc);
    check("instret", instret, exp_instret);
    if (!exp_have) check("imem_addr", imem_addr, exp_pc);
    else check("instr", instr, mem_word(exp_pc));

    check("hi_req", imem_req_hi, !hi_have);
    check("hi_instret", instret_hi, hi_retired);
    if (!hi_have) begin
      check("hi_addr", imem_addr_hi, hi_addr(hi_idx));
      hi_idx++;
      hi_have = 1;
    end else begin
      check("hi_instr", instr_hi, 32'h0000_0040);
      hi_retired++;
      hi_have = 0;
    end

    imem_ready = rdy;
    stall      = stl;
    dobranch   = br;
    dojump     = jp;
    imem_rdata = imem_req ? mem_word(imem_addr) : $urandom;

    if (exp_have && !stl) begin
      ins = mem_word(exp_pc);
      pc4 = exp_pc + 32'd4;
      if (jp) tgt = {pc4[31:28], ins[25:0], 2'b00};
      else    tgt = pc4 + {{16{ins[15]}}, ins[15:0]} * 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
      if (pend) begin
        exp_pc = pend_tgt;
        pend   = 0;
      end else begin
        if (br || jp) begin
          pend     = 1;
          pend_tgt = tgt;
        end
        exp_pc = pc4;
      end
`else
      exp_pc = (br || jp) ? tgt : pc4;
`endif
      exp_instret++;
      exp_have = 0;
    end else if (!exp_have && rdy) begin
      exp_have = 1;
      fetch_log.push_back(exp_pc);
    end
  endtask

  // Asserts reset asynchronously mid-cycle and releases it at a falling edge.
  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_valid", instr_valid, 0);
    check("rst_instret", instret, 0);
    check("rst_req", imem_req, 0);
    repeat (2) @(negedge clk);
    check("rst_req_held", imem_req, 0);
    check("rst_hi_req", imem_req_hi, 0);
    reset = 1'b1;
    exp_pc = RESET_PC;
    exp_instret = 0;
    exp_have = 0;
    pend = 0;
    fetch_log.delete();
    hi_idx = 0;
    hi_have = 0;
    hi_retired = 0;
  endtask

  task automatic run_to_issue(input logic [31:0] a, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (instr_valid && pc == a) found = 1;
      else step(1, 0, 0, 0);
    end
    check(tag, found, 1);
  endtask

  task automatic run_to_fetch(input logic [31:0] a, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == a) found = 1;
      else step(1, 0, 0, 0);
    end
    check(tag, found, 1);
  endtask

  initial begin
    logic [7:0] vbits;
    reset = 1'b1;
    imem_ready = 0;
    stall = 0;
    dobranch = 0;
    dojump = 0;
    imem_rdata = 0;
    ov[32'h10]  = 32'h0000_0010;
    ov[32'h20]  = 32'h0000_FFFE;
    ov[32'h28]  = 32'h0000_0035;
    ov[32'h100] = 32'h0800_0050;

    // straight-line code, ready every request
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vbits[i] = instr_valid;
      step(1, 0, 0, 0);
    end
    @(negedge clk);
    check("instret_8cyc", instret, 4);
    check("valid_alternates", vbits, 8'hAA);
    check("log_len", fetch_log.size(), 4);
    for (int i = 0; i < 4 && i < fetch_log.size(); i++) check("log_seq", fetch_log[i], 4 * i);
    step(1, 0, 0, 0);

    // memory slow on address 8
    apply_reset();
    run_to_fetch(32'h8, "reach_fetch_8");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_valid", instr_valid, 0);
      check("wait_instret", instret, 2);
      step(0, 0, 0, 0);
    end
    @(negedge clk);
    step(1, 0, 0, 0);

    // stall with dobranch toggling at 0x10
    run_to_issue(32'h10, "reach_issue_10");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_instret", instret, 4);
      step(1, 1, (i % 2 == 0), 0);
    end
    @(negedge clk);
    step(1, 0, 0, 0);
    @(negedge clk);
    check("after_stall_addr", imem_addr, 32'h14);
    step(1, 0, 0, 0);

    // backward branch at 0x20
    run_to_issue(32'h20, "reach_issue_20");
    step(1, 0, 1, 0);
    @(negedge clk);
`ifdef FETCH_DELAY_SLOT_EN
    check("branch_next", imem_addr, 32'h24);
`else
    check("branch_next", imem_addr, 32'h1C);
`endif
    step(1, 0, 0, 0);

    // forward branch at 0x28 to 0x100: fetch order shows the slot if enabled
    run_to_issue(32'h28, "reach_issue_28");
    fetch_log.delete();
    step(1, 0, 1, 0);
    run_to_issue(32'h100, "reach_issue_100");
`ifdef FETCH_DELAY_SLOT_EN
    check("slot_log_len", fetch_log.size(), 2);
    if (fetch_log.size() == 2) begin
      check("slot_log0", fetch_log[0], 32'h2C);
      check("slot_log1", fetch_log[1], 32'h100);
    end
`else
    check("slot_log_len", fetch_log.size(), 1);
    if (fetch_log.size() == 1) check("slot_log0", fetch_log[0], 32'h100);
`endif

    // jump at 0x100 to 0x140
    step(1, 0, 0, 1);
    @(negedge clk);
`ifdef FETCH_DELAY_SLOT_EN
    check("jump_next", imem_addr, 32'h104);
`else
    check("jump_next", imem_addr, 32'h140);
`endif
    step(1, 0, 0, 0);

    // reset in the middle of a request at 0x44
    apply_reset();
    run_to_fetch(32'h44, "reach_fetch_44");
    step(0, 0, 0, 0);
    apply_reset();
    @(negedge clk);
    check("restart_addr", imem_addr, RESET_PC);
    check("restart_req", imem_req, 1);
    step(1, 0, 0, 0);

    // randomized handshakes, stalls, branches and jumps
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      step($urandom_range(9) < 7, $urandom_range(9) < 3, $urandom_range(3) == 0, $urandom_range(3) == 0);
      if ($urandom_range(599) == 0) apply_reset();
    end
    @(negedge clk);
    step(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
